// File: rtl/game_referee_if.sv
// Round-result inputs and match-status outputs between the Correlation stage, its controller and game_referee.
// No flow control: round results are offered with guess_valid and taken only while a game is in play.
interface game_referee_if #(
  parameter int CR_W       = 10,
  parameter int MAX_ROUNDS = 8,
  parameter int WIN_GAMES  = 3
);
  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int WW = $clog2(WIN_GAMES + 1);

  logic            start;
  logic            guess_valid;
  logic [1:0]      Correct_guess;
  logic [CR_W-1:0] Out_cr;
  logic            game_clear;
  logic [RW-1:0]   round_cnt;
  logic [WW-1:0]   wins_first;
  logic [WW-1:0]   wins_second;
  logic [1:0]      game_winner;
  logic            game_done;
  logic            match_over;
  logic            busy;

  modport master (
    output start, guess_valid, Correct_guess, Out_cr,
    input  game_clear, round_cnt, wins_first, wins_second, game_winner,
           game_done, match_over, busy
  );

  modport slave (
    input  start, guess_valid, Correct_guess, Out_cr,
    output game_clear, round_cnt, wins_first, wins_second, game_winner,
           game_done, match_over, busy
  );
endinterface

// File: rtl/game_referee.sv
// Match referee: judges games from round results and counts game wins until one player reaches WIN_GAMES.
// Latency: deciding round at edge N gives game_done in N+1 and game_clear in N+2; guess_valid is dropped outside PLAY (no backpressure).
module game_referee #(
  parameter int CR_W       = 10,
  parameter int MAX_ROUNDS = 8,
  parameter int WIN_GAMES  = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  game_referee_if.slave bus
);
  localparam int RW = $clog2(MAX_ROUNDS + 1);
  localparam int WW = $clog2(WIN_GAMES + 1);
  localparam int HW = CR_W - CR_W / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_JUDGE = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   round_q, round_d, round_inc;
  logic [WW-1:0]   wins_first_q, wins_first_d;
  logic [WW-1:0]   wins_second_q, wins_second_d;
  logic [1:0]      winner_q, winner_d;
  logic [1:0]      guess_q, guess_d;
  logic [CR_W-1:0] cr_q, cr_d;
  logic [HW-1:0]   score_first, score_second;
  logic [1:0]      verdict;

  assign round_inc    = round_q + RW'(1);
  assign score_first  = cr_q[CR_W-1:CR_W/2];
  assign score_second = HW'(cr_q[CR_W/2-1:0]);

  // A correct guess decides the game outright; otherwise the closer correlation wins.
  always_comb begin
    verdict = guess_q;
    if (guess_q == 2'b00) begin
      if (score_first > score_second)      verdict = 2'b01;
      else if (score_second > score_first) verdict = 2'b10;
      else                                 verdict = 2'b11;
    end
  end

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    wins_first_d  = wins_first_q;
    wins_second_d = wins_second_q;
    winner_d      = winner_q;
    guess_d       = guess_q;
    cr_d          = cr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          wins_first_d  = '0;
          wins_second_d = '0;
          winner_d      = 2'b00;
          state_d       = S_CLEAR;
        end
      end
      S_PLAY: begin
        if (bus.guess_valid) begin
          round_d = round_inc;
          guess_d = bus.Correct_guess;
          cr_d    = bus.Out_cr;
          if (bus.Correct_guess != 2'b00 || round_inc == RW'(MAX_ROUNDS))
            state_d = S_JUDGE;
        end
      end
      S_JUDGE: begin
        winner_d = verdict;
        if (verdict == 2'b01) wins_first_d  = wins_first_q + WW'(1);
        if (verdict == 2'b10) wins_second_d = wins_second_q + WW'(1);
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        round_d = '0;
        if (wins_first_q == WW'(WIN_GAMES) || wins_second_q == WW'(WIN_GAMES))
          state_d = S_DONE;
        else
          state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      round_q       <= '0;
      wins_first_q  <= '0;
      wins_second_q <= '0;
      winner_q      <= 2'b00;
      guess_q       <= 2'b00;
      cr_q          <= '0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      wins_first_q  <= wins_first_d;
      wins_second_q <= wins_second_d;
      winner_q      <= winner_d;
      guess_q       <= guess_d;
      cr_q          <= cr_d;
    end
  end

  assign bus.game_clear  = (state_q == S_CLEAR);
  assign bus.game_done   = (state_q == S_JUDGE);
  assign bus.match_over  = (state_q == S_DONE);
  assign bus.busy        = (state_q == S_PLAY) || (state_q == S_JUDGE) || (state_q == S_CLEAR);
  assign bus.round_cnt   = round_q;
  assign bus.wins_first  = wins_first_q;
  assign bus.wins_second = wins_second_q;
  assign bus.game_winner = winner_q;
endmodule
